// File: rtl/ad5674_spi_tx.sv
// ad5674_spi_tx
//
// Serialises DAC write requests into 24-bit "write and update" frames for two
// AD5674 devices that share SCLK/SDIN and have one SYNC line each.
//
// Frame word: {CMD, ch[3:0], din[11:0], 4'h0}, sent MSB first.
// Bits are launched while SCLK rises and sampled by the DAC when SCLK falls.
//
// Request handshake: ad5674_trig is a fire-and-forget strobe (valid with no
// ready). ad5674_ch and ad5674_din are sampled on the same cycle.
// - A trig while the block is idle starts a frame on the next edge.
// - A trig while busy lands in a single pending slot.
// - Overwriting a full slot pulses drop.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   ad5674_trig       one-cycle request strobe
//   ad5674_ch[4:0]    [4] device select, [3:0] channel address
//   ad5674_din[11:0]  DAC code
//   dac_sclk          serial clock, idles high
//   dac_sync_n[1:0]   per-device frame select, active low
//   dac_sdin          serial data, MSB first
//   busy              high from frame start until the end of the sync gap
//   done              one-cycle pulse in the first cycle SYNC is high again
//   drop              one-cycle pulse when a pending request is lost
//   dbg_state[1:0]    current FSM state (IDLE=0, SHIFT=1, HOLD=2, GAP=3)
module ad5674_spi_tx #(
  parameter int          CLK_DIV  = 4,
  parameter int          SYNC_GAP = 4,
  parameter logic [3:0]  CMD      = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad5674_trig,
  input  logic [4:0]  ad5674_ch,
  input  logic [11:0] ad5674_din,
  output logic        dac_sclk,
  output logic [1:0]  dac_sync_n,
  output logic        dac_sdin,
  output logic        busy,
  output logic        done,
  output logic        drop,
  output logic [1:0]  dbg_state
);

  localparam int CMAX = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SYNC_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   sh_q, sh_d;
  logic          sclk_q, sclk_d;
  logic [1:0]    sync_q, sync_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          pend_v_q, pend_v_d;
  logic [4:0]    pend_ch_q, pend_ch_d;
  logic [11:0]   pend_din_q, pend_din_d;

  // Frame-start request and the data it loads (live input or pending slot).
  logic          load_en;
  logic [4:0]    load_ch;
  logic [11:0]   load_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      sclk_q     <= 1'b1;
      sync_q     <= 2'b11;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_ch_q  <= '0;
      pend_din_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      sclk_q     <= sclk_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      pend_v_q   <= pend_v_d;
      pend_ch_q  <= pend_ch_d;
      pend_din_q <= pend_din_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    sclk_d     = sclk_q;
    sync_d     = sync_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    pend_v_d   = pend_v_q;
    pend_ch_d  = pend_ch_q;
    pend_din_d = pend_din_q;
    load_en    = 1'b0;
    load_ch    = ad5674_ch;
    load_din   = ad5674_din;

    case (state_q)
      S_IDLE: begin
        if (ad5674_trig) load_en = 1'b1;
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;                 // DAC samples the current bit here
          end else if (bit_q == 5'd23) begin
            sclk_d  = 1'b1;                // last low phase done; park SCLK high
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b1;
            sh_d   = {sh_q[22:0], 1'b0};   // next bit goes out with the rise
            bit_d  = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sync_d  = 2'b11;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (ad5674_trig) begin
            // The live request wins over a waiting one; the waiting one is lost.
            load_en  = 1'b1;
            drop_d   = pend_v_q;
            pend_v_d = 1'b0;
          end else if (pend_v_q) begin
            load_en  = 1'b1;
            load_ch  = pend_ch_q;
            load_din = pend_din_q;
            pend_v_d = 1'b0;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A trig that does not start a frame goes into the single pending slot.
    if (ad5674_trig && (state_q != S_IDLE) && !load_en) begin
      pend_ch_d  = ad5674_ch;
      pend_din_d = ad5674_din;
      pend_v_d   = 1'b1;
      drop_d     = pend_v_q;
    end

    if (load_en) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      bit_d   = '0;
      sh_d    = {CMD, load_ch[3:0], load_din, 4'h0};
      sclk_d  = 1'b1;
      sync_d  = load_ch[4] ? 2'b01 : 2'b10;
      busy_d  = 1'b1;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_q;
  assign dac_sdin   = sh_q[23];
  assign busy       = busy_q;
  assign done       = done_q;
  assign drop       = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ad5674_spi_tx.sv
// Bench for ad5674_spi_tx (CLK_DIV=4, SYNC_GAP=4).
// The reference model tracks frames as time windows: a frame that starts at
// edge s holds SYNC low for s..s+49*D-1 and keeps busy until s+49*D+G-1.
// From those windows it predicts every output cycle by cycle.
// A separate decoder rebuilds each frame word from SCLK falls.
module tb_ad5674_spi_tx;
  localparam int D  = 4;
  localparam int G  = 4;
  localparam int FL = 49 * D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [4:0]  ch;
  logic [11:0] din;
  logic        dac_sclk;
  logic [1:0]  dac_sync_n;
  logic        dac_sdin;
  logic        busy;
  logic        done;
  logic        drop;
  logic [1:0]  dbg_state;

  ad5674_spi_tx #(.CLK_DIV(D), .SYNC_GAP(G), .CMD(4'h3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ad5674_trig(trig),
    .ad5674_ch  (ch),
    .ad5674_din (din),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_sdin   (dac_sdin),
    .busy       (busy),
    .done       (done),
    .drop       (drop),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int          t      = 0;
  int          s_cur  = -100000;
  int          end_t  = 0;
  logic [23:0] cur_word = '0;
  logic        cur_dev  = 1'b0;
  logic        pend_v   = 1'b0;
  logic [4:0]  pend_ch  = '0;
  logic [11:0] pend_din = '0;
  logic        drop_exp = 1'b0;
  logic [24:0] exp_q[$];

  // decoder / observation state
  logic        sclk_prev = 1'b1;
  logic        sdin_prev = 1'b0;
  logic [1:0]  sync_prev = 2'b11;
  logic [23:0] bits      = '0;
  logic        dec_dev   = 1'b0;
  int          falls = 0, low_cnt = 0, rise_t = 0, last_gap = 0;
  logic [23:0] last_word = '0;
  logic        last_dev  = 1'b0;
  int          frames = 0, done_cnt = 0, drop_cnt = 0;

  function automatic logic [23:0] mk(input logic [4:0] c, input logic [11:0] d);
    return {4'h3, c[3:0], d, 4'h0};
  endfunction

  task automatic model_start(input logic [4:0] c, input logic [11:0] d);
    s_cur    = t;
    end_t    = t + FL + G;
    cur_word = mk(c, d);
    cur_dev  = c[4];
    exp_q.push_back({c[4], mk(c, d)});
  endtask

  // Runs at every falling edge: compare outputs of the last rising edge,
  // decode the serial bus, then advance the model by the coming edge.
  task automatic monitor_loop();
    int   p;
    logic infr, shf;
    logic [1:0] sync_exp;
    logic sclk_exp;
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pend_v    = 1'b0;
        s_cur     = -100000;
        t++;
        end_t     = t;
        drop_exp  = 1'b0;
        sync_prev = 2'b11;
        sclk_prev = 1'b1;
        sdin_prev = 1'b0;
        falls     = 0;
        low_cnt   = 0;
      end else begin
        p    = t - s_cur;
        infr = (p >= 0) && (p < FL);
        shf  = (p >= 0) && (p < 48 * D);
        sync_exp = infr ? (cur_dev ? 2'b01 : 2'b10) : 2'b11;
        sclk_exp = shf ? (((p / D) % 2) == 0) : 1'b1;
        check_val("sync_n", 32'(dac_sync_n), 32'(sync_exp));
        check_val("sclk", 32'(dac_sclk), 32'(sclk_exp));
        if (shf) check_val("sdin", 32'(dac_sdin), 32'(cur_word[23 - (p / D) / 2]));
        check_val("busy", 32'(busy), 32'(t < end_t));
        check_val("done", 32'(done), 32'(p == FL));
        check_val("drop", 32'(drop), 32'(drop_exp));

        // decoder
        if (dac_sdin !== sdin_prev) check_val("sdin_moves_while_sclk_high", 32'(dac_sclk), 1);
        if (dac_sync_n != 2'b11 && sync_prev == 2'b11) begin
          last_gap = t - rise_t;
          falls    = 0;
          low_cnt  = 0;
          bits     = '0;
        end
        if (sclk_prev && !dac_sclk && dac_sync_n != 2'b11) begin
          bits = {bits[22:0], sdin_prev};
          falls++;
        end
        if (dac_sync_n != 2'b11) begin
          low_cnt++;
          dec_dev = (dac_sync_n == 2'b01);
        end
        if (sync_prev != 2'b11 && dac_sync_n == 2'b11) begin
          rise_t    = t;
          last_word = bits;
          last_dev  = dec_dev;
          frames++;
          check_val("frame_falls", 32'(falls), 24);
          check_val("frame_sync_low", 32'(low_cnt), 32'(FL));
          check_val("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("frame_word", {7'd0, dec_dev, bits}, {7'd0, e});
          end
        end
        if (done) done_cnt++;
        if (drop) drop_cnt++;
        sclk_prev = dac_sclk;
        sdin_prev = dac_sdin;
        sync_prev = dac_sync_n;

        // advance model by the next rising edge
        t++;
        drop_exp = 1'b0;
        if (t >= end_t) begin
          if (trig) begin
            drop_exp = pend_v;
            pend_v   = 1'b0;
            model_start(ch, din);
          end else if (pend_v) begin
            pend_v = 1'b0;
            model_start(pend_ch, pend_din);
          end
        end else if (trig) begin
          drop_exp = pend_v;
          pend_v   = 1'b1;
          pend_ch  = ch;
          pend_din = din;
        end
      end
    end
  endtask

  // driver tasks (entered and left at posedge + 1)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] c, input logic [11:0] d);
    trig = 1'b1;
    ch   = c;
    din  = d;
    step(1);
    trig = 1'b0;
    ch   = 5'($urandom);
    din  = 12'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step(1);
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    check_val("idle_wait", 32'(busy), 0);
  endtask

  int fr0, dr0, dc0, n;

  initial begin
    rst_n = 1'b0;
    trig  = 1'b0;
    ch    = '0;
    din   = '0;
    fork
      monitor_loop();
    join_none
    step(3);
    rst_n = 1'b1;
    step(2);
    check_val("rst_sclk", 32'(dac_sclk), 1);
    check_val("rst_sync", 32'(dac_sync_n), 32'h3);
    check_val("rst_sdin", 32'(dac_sdin), 0);
    check_val("rst_busy", 32'(busy), 0);

    // basic frame on device 0
    send(5'd3, 12'hABC);
    wait_idle(400);
    check_val("f1_word", 32'(last_word), 32'h33ABC0);
    check_val("f1_dev", 32'(last_dev), 0);

    // frame on device 1
    send(5'd18, 12'h001);
    wait_idle(400);
    check_val("f2_word", 32'(last_word), 32'h320010);
    check_val("f2_dev", 32'(last_dev), 1);

    // two trigs during one frame: one drop, last one sent, gap of G
    fr0 = frames; dr0 = drop_cnt;
    send(5'd0, 12'h100);
    step(10);
    send(5'd1, 12'h111);
    step(10);
    send(5'd2, 12'h222);
    wait_idle(800);
    check_val("ovr_drops", 32'(drop_cnt - dr0), 1);
    check_val("ovr_frames", 32'(frames - fr0), 2);
    check_val("ovr_word", 32'(last_word), 32'h322220);
    check_val("ovr_gap", 32'(last_gap), 32'(G));

    // reset in the middle of a frame
    fr0 = frames; dc0 = done_cnt;
    send(5'd5, 12'h555);
    step(100);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_sclk", 32'(dac_sclk), 1);
    check_val("rst_mid_sync", 32'(dac_sync_n), 32'h3);
    check_val("rst_mid_busy", 32'(busy), 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    check_val("rst_mid_no_done", 32'(done_cnt), 32'(dc0));
    check_val("rst_mid_no_frame", 32'(frames), 32'(fr0));
    send(5'd21, 12'h777);
    wait_idle(400);
    check_val("post_rst_word", 32'(last_word), 32'h357770);
    check_val("post_rst_dev", 32'(last_dev), 1);

    // trig in the last gap cycle with a full pending slot
    fr0 = frames; dr0 = drop_cnt;
    send(5'd7, 12'h070);
    step(20);
    send(5'd8, 12'h080);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1000);
    check_val("gap_done_seen", 32'(done), 1);
    repeat (G - 1) @(posedge clk);
    #1;
    send(5'd9, 12'h090);
    wait_idle(800);
    check_val("gap_drops", 32'(drop_cnt - dr0), 1);
    check_val("gap_frames", 32'(frames - fr0), 2);
    check_val("gap_word", 32'(last_word), 32'h390900);
    check_val("gap_sync_high", 32'(last_gap), 32'(G));

    // channel sweep, one request per idle period
    fr0 = frames; dr0 = drop_cnt;
    for (int c = 0; c < 32; c++) begin
      send(5'(c), 12'(c * 37 + 5));
      step(250);
    end
    check_val("sweep_frames", 32'(frames - fr0), 32);
    check_val("sweep_drops", 32'(drop_cnt - dr0), 0);

    // random requests, including bursts that overwrite the pending slot
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(1, 260));
      send(5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)));
    end
    wait_idle(2000);
    check_val("final_exp_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
